// File: rtl/sifh_sram_sched.sv
// Two-requester SRAM scheduler with full-memory clear sweeps after every reset or on request.
// Optional SIFH_RR_EN macro: round-robin tie-breaking instead of fixed priority for requester 0.
module sifh_sram_sched #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 8
) (
    input  logic            clk,
    input  logic            res,
    input  logic            clr_start,
    output logic            clr_busy,
    output logic            clr_done,
    input  logic [1:0]      req,
    output logic [1:0]      gnt,
    input  logic [2*AW-1:0] rq_waddr,
    input  logic [2*AW-1:0] rq_raddr,
    input  logic [2*DW-1:0] rq_wdata,
    input  logic [1:0]      rq_we,
    input  logic [1:0]      rq_re,
    output logic [DW-1:0]   rd_data,
    output logic [1:0]      rd_valid,
    input  logic [DW-1:0]   counts,
    output logic [AW-1:0]   waddr,
    output logic [AW-1:0]   raddr,
    output logic            wEnable,
    output logic            rEnable,
    output logic            writeFlag,
    output logic            readFlag,
    output logic [DW-1:0]   newCounts
);

    localparam int unsigned   DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [1:0] S_CLR  = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_OWN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rdp_q, rdp_d;
    logic [1:0]    rdv_q, rdv_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wen_q, wen_d;
    logic          wflag_q, wflag_d;
    logic          ren_q, ren_d;
    logic          rflag_q, rflag_d;
    logic          own;
    logic          win;
`ifdef SIFH_RR_EN
    logic          ptr_q, ptr_d;
`endif

    assign own = gnt_q[1];

    // Winner index, only meaningful when at least one req bit is set.
    always_comb begin
`ifdef SIFH_RR_EN
        win = (req == 2'b11) ? ptr_q : req[1];
`else
        win = ~req[0];
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        gnt_d   = gnt_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        wflag_d = 1'b0;
        ren_d   = 1'b1;
        rflag_d = 1'b0;
        rdp_d   = '0;
        rdv_d   = rdp_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SIFH_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_CLR: begin
                waddr_d = cnt_q;
                wdata_d = '0;
                wen_d   = 1'b1;
                wflag_d = 1'b1;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // busy_q is still set only on the edge right after the last clear write.
                done_d = busy_q;
                if (clr_start || pend_q) begin
                    state_d = S_CLR;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end else if (|req) begin
                    state_d = S_OWN;
                    gnt_d   = win ? 2'b10 : 2'b01;
`ifdef SIFH_RR_EN
                    ptr_d   = ~win;
`endif
                end
            end
            S_OWN: begin
                if (clr_start) begin
                    pend_d = 1'b1;
                end
                if (!req[own]) begin
                    gnt_d   = '0;
                    state_d = S_IDLE;
                end
                if (rq_we[own]) begin
                    waddr_d = own ? rq_waddr[2*AW-1:AW] : rq_waddr[AW-1:0];
                    wdata_d = own ? rq_wdata[2*DW-1:DW] : rq_wdata[DW-1:0];
                    wen_d   = 1'b1;
                    wflag_d = 1'b1;
                end
                if (rq_re[own]) begin
                    raddr_d = own ? rq_raddr[2*AW-1:AW] : rq_raddr[AW-1:0];
                    ren_d   = 1'b0;
                    rflag_d = 1'b1;
                    rdp_d   = gnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset parks the FSM in CLR at address 0, so the first released edge starts a sweep.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= S_CLR;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            gnt_q   <= '0;
            rdp_q   <= '0;
            rdv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            wflag_q <= 1'b0;
            ren_q   <= 1'b1;
            rflag_q <= 1'b0;
`ifdef SIFH_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            gnt_q   <= gnt_d;
            rdp_q   <= rdp_d;
            rdv_q   <= rdv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            wflag_q <= wflag_d;
            ren_q   <= ren_d;
            rflag_q <= rflag_d;
`ifdef SIFH_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign clr_busy  = busy_q;
    assign clr_done  = done_q;
    assign gnt       = gnt_q;
    assign rd_valid  = rdv_q;
    assign rd_data   = counts;
    assign waddr     = waddr_q;
    assign raddr     = raddr_q;
    assign newCounts = wdata_q;
    assign wEnable   = wen_q;
    assign writeFlag = wflag_q;
    assign rEnable   = ren_q;
    assign readFlag  = rflag_q;

endmodule

// File: tb/tb_sifh_sram_sched.sv
// Bench for sifh_sram_sched (AW=4, DW=8): table-driven owner accesses, read scoreboard, clear/reset sequences.
// Honours SIFH_RR_EN when the design is built with it.
module tb_sifh_sram_sched;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          res;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic [1:0]    req;
    logic [1:0]    gnt;
    logic [7:0]    rq_waddr;
    logic [7:0]    rq_raddr;
    logic [15:0]   rq_wdata;
    logic [1:0]    rq_we;
    logic [1:0]    rq_re;
    logic [7:0]    rd_data;
    logic [1:0]    rd_valid;
    logic [7:0]    counts;
    logic [3:0]    waddr;
    logic [3:0]    raddr;
    logic          wEnable;
    logic          rEnable;
    logic          writeFlag;
    logic          readFlag;
    logic [7:0]    newCounts;

    sifh_sram_sched #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .res(res), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .req(req), .gnt(gnt), .rq_waddr(rq_waddr), .rq_raddr(rq_raddr), .rq_wdata(rq_wdata),
        .rq_we(rq_we), .rq_re(rq_re), .rd_data(rd_data), .rd_valid(rd_valid), .counts(counts),
        .waddr(waddr), .raddr(raddr), .wEnable(wEnable), .rEnable(rEnable),
        .writeFlag(writeFlag), .readFlag(readFlag), .newCounts(newCounts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [7:0]  wd;
        logic        ow;   // non-owner slot also strobes
        logic [11:0] ex;   // {wEnable, writeFlag, rEnable, readFlag, waddr, raddr}
    } vec_t;

    typedef struct {
        logic [1:0] who;
        logic [7:0] data;
        int         due;
    } sb_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    sb_t  sbq[$];
    logic [7:0] dmem [16];
    logic [7:0] exp_mem [16];
    vec_t tv [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance one cycle acting as the SRAM, then score any read-data-valid.
    task automatic tick();
        logic       wr, rd;
        logic [3:0] wa, ra;
        logic [7:0] wd;
        sb_t        e;
        wr = writeFlag && wEnable;
        rd = readFlag && !rEnable;
        wa = waddr;
        ra = raddr;
        wd = newCounts;
        @(posedge clk);
        #1;
        if (wr === 1'b1) dmem[wa] = wd;
        if (rd === 1'b1) counts = dmem[ra];
        else counts = 8'($urandom);
        cyc++;
        #1;
        if (rd_valid !== 2'b00) begin
            if (sbq.size() == 0) begin
                chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("rd_scoreboard", 64'({rd_valid, rd_data, cyc}), 64'({e.who, e.data, e.due}));
            end
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic [3:0] wa,
                                input logic [3:0] ra, input logic [7:0] wd, input logic ow,
                                input logic [11:0] ex);
        vec_t v;
        v.we = we; v.re = re; v.wa = wa; v.ra = ra; v.wd = wd; v.ow = ow; v.ex = ex;
        return v;
    endfunction

    task automatic reset_chk(input string nm);
        chk(nm, 64'({clr_busy, clr_done, gnt, rd_valid, wEnable, writeFlag, rEnable, readFlag,
                     waddr, raddr, newCounts}),
            64'({1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00}));
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("%s_addr%0d", nm, i),
                64'({clr_busy, clr_done, gnt, rd_valid, wEnable, writeFlag, rEnable, readFlag,
                     waddr, newCounts}),
                64'({1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'(i), 8'h00}));
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] tie_gnt;
        sb_t        e;

        tv[0] = mk(1'b1, 1'b0, 4'd5, 4'd0, 8'h3A, 1'b0, 12'hE50);
        tv[1] = mk(1'b1, 1'b0, 4'd7, 4'd0, 8'h11, 1'b0, 12'hE70);
        tv[2] = mk(1'b0, 1'b1, 4'd0, 4'd7, 8'h00, 1'b1, 12'h177);
        tv[3] = mk(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 12'h277);
        tv[4] = mk(1'b1, 1'b1, 4'd2, 4'd5, 8'hC4, 1'b0, 12'hD25);
        tv[5] = mk(1'b0, 1'b1, 4'd0, 4'd9, 8'h00, 1'b0, 12'h129);
        tv[6] = mk(1'b1, 1'b0, 4'd9, 4'd0, 8'hFF, 1'b1, 12'hE99);
        tv[7] = mk(1'b0, 1'b1, 4'd0, 4'd9, 8'h00, 1'b0, 12'h199);
        tv[8] = mk(1'b0, 1'b1, 4'd0, 4'd15, 8'h00, 1'b1, 12'h19F);
        tv[9] = mk(1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 12'h29F);

        for (int i = 0; i < 16; i++) begin
            dmem[i]    = 8'(i * 13 + 5);
            exp_mem[i] = 8'h00;
        end

        res = 1'b0; clr_start = 1'b0; req = 2'b00;
        rq_waddr = '0; rq_raddr = '0; rq_wdata = '0; rq_we = '0; rq_re = '0; counts = '0;

        for (int i = 0; i < 3; i++) tick();
        reset_chk("reset_values");

        // Power-up sweep.
        res = 1'b1;
        sweep("init_clr");
        tick();
        chk("init_clr_done", 64'({clr_busy, clr_done, gnt, wEnable, writeFlag, waddr}),
            64'({1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'd15}));
        tick();
        chk("init_clr_done_pulse", 64'({clr_busy, clr_done, gnt}), 64'({1'b0, 1'b0, 2'b00}));

        // Tie-breaking with both requesters held.
`ifdef SIFH_RR_EN
        tie_gnt = 2'b10;
`else
        tie_gnt = 2'b01;
`endif
        req = 2'b11;
        tick();
        chk("tie_first_gnt", 64'(gnt), 64'(2'b01));
        req = 2'b10;
        tick();
        chk("tie_release_gnt", 64'(gnt), 64'(2'b00));
        req = 2'b11;
        tick();
        chk("tie_second_gnt", 64'(gnt), 64'(tie_gnt));
        req = 2'b00;
        tick();
        chk("tie_final_release", 64'(gnt), 64'(2'b00));

        // Owner 0 table with non-owner strobes on slot 1.
        req = 2'b01;
        tick();
        chk("own0_gnt", 64'(gnt), 64'(2'b01));
        for (int k = 0; k < 10; k++) begin
            rq_we    = {tv[k].ow, tv[k].we};
            rq_re    = {tv[k].ow, tv[k].re};
            rq_waddr = {4'hC, tv[k].wa};
            rq_raddr = {4'hD, tv[k].ra};
            rq_wdata = {8'h99, tv[k].wd};
            if (tv[k].re) begin
                e.who = 2'b01; e.data = exp_mem[tv[k].ra]; e.due = cyc + 2;
                sbq.push_back(e);
            end
            if (tv[k].we) exp_mem[tv[k].wa] = tv[k].wd;
            tick();
            chk($sformatf("vec%0d_pins", k),
                64'({wEnable, writeFlag, rEnable, readFlag, waddr, raddr}), 64'(tv[k].ex));
            if (tv[k].we) chk($sformatf("vec%0d_wdata", k), 64'(newCounts), 64'(tv[k].wd));
            chk($sformatf("vec%0d_gnt", k), 64'(gnt), 64'(2'b01));
        end
        rq_we = '0; rq_re = '0; req = 2'b00;
        tick();
        chk("own0_release", 64'(gnt), 64'(2'b00));

        // Clear requested mid-grant is deferred until release, then precedes the next grant.
        req = 2'b01;
        tick();
        chk("pend_gnt", 64'(gnt), 64'(2'b01));
        clr_start = 1'b1; req = 2'b11;
        tick();
        chk("pend_hold", 64'({clr_busy, gnt}), 64'({1'b0, 2'b01}));
        clr_start = 1'b0;
        tick();
        chk("pend_hold2", 64'({clr_busy, gnt}), 64'({1'b0, 2'b01}));
        req = 2'b10;
        tick();
        chk("pend_release", 64'({clr_busy, gnt}), 64'({1'b0, 2'b00}));
        tick();
        chk("pend_dead", 64'({clr_busy, gnt}), 64'({1'b0, 2'b00}));
        sweep("pend_clr");
        tick();
        chk("pend_done_then_gnt1", 64'({clr_busy, clr_done, gnt}), 64'({1'b0, 1'b1, 2'b10}));

        // Owner 1 write+read; slot 0 strobes must be ignored.
        rq_we = 2'b11; rq_re = 2'b11;
        rq_waddr = {4'd3, 4'd12}; rq_raddr = {4'd5, 4'd13}; rq_wdata = {8'h77, 8'h99};
        e.who = 2'b10; e.data = exp_mem[5]; e.due = cyc + 2;
        sbq.push_back(e);
        exp_mem[3] = 8'h77;
        tick();
        chk("own1_pins", 64'({wEnable, writeFlag, rEnable, readFlag, waddr, raddr, newCounts}),
            64'({1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd5, 8'h77}));
        rq_we = '0; rq_re = '0;
        tick();
        tick();
        req = 2'b00;
        tick();
        chk("own1_release", 64'(gnt), 64'(2'b00));

        // Reset mid-sweep restarts from address 0.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("abort_addr%0d", i), 64'({clr_busy, waddr, wEnable}),
                64'({1'b1, 4'(i), 1'b1}));
        end
        res = 1'b0;
        tick();
        reset_chk("abort_reset_values");
        res = 1'b1;
        sweep("restart_clr");
        tick();
        chk("restart_done", 64'({clr_busy, clr_done, gnt}), 64'({1'b0, 1'b1, 2'b00}));

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
